// File: rtl/multdiv_pkg.sv
// Shared types and rstatus constants for the multiply/divide issue controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  function automatic logic [31:0] rstatus_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MULT;
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Clearable saturating cycle counter; flags when the count equals TIMEOUT.
module multdiv_watchdog
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the X stage and multdiv: start pulse, operand hold,
// pipeline stall, timeout watchdog and writeback of result or rstatus code.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        issue_valid_i,
  input  logic        issue_is_div_i,
  input  logic [31:0] issue_A_i,
  input  logic [31:0] issue_B_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        flush_i,
  output logic        ctrl_MULT_o,
  output logic        ctrl_DIV_o,
  output logic [31:0] data_operandA_o,
  output logic [31:0] data_operandB_o,
  input  logic [31:0] data_result_i,
  input  logic        data_exception_i,
  input  logic        data_resultRDY_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_result_o,
  output logic        wb_exception_o
);

  state_e      state_q, state_d;
  logic        div_q;
  logic [4:0]  rd_q;
  logic [31:0] op_a_q, op_b_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_result_q;
  logic        wb_exc_q;
  logic        accept, capture, timeout_hit;

  multdiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear_i    (state_q == ST_START),
    .count_en_i (state_q == ST_WAIT),
    .expired_o  (timeout_hit)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid_i) begin
          state_d = ST_START;
          accept  = 1'b1;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (data_resultRDY_i || timeout_hit) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flush kills whatever is in flight, including a same-cycle accept or completion.
    if (flush_i) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      div_q       <= 1'b0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      wb_rd_q     <= '0;
      wb_result_q <= '0;
      wb_exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        div_q  <= issue_is_div_i;
        rd_q   <= issue_rd_i;
        op_a_q <= issue_A_i;
        op_b_q <= issue_B_i;
      end
      if (capture) begin
        // RDY wins over a same-cycle timeout; otherwise the op ends in rstatus.
        if (data_resultRDY_i && !data_exception_i) begin
          wb_rd_q     <= rd_q;
          wb_result_q <= data_result_i;
          wb_exc_q    <= 1'b0;
        end else begin
          wb_rd_q     <= RSTATUS_REG;
          wb_result_q <= rstatus_code(div_q);
          wb_exc_q    <= 1'b1;
        end
      end
    end
  end

  assign ctrl_MULT_o     = (state_q == ST_START) && !div_q && !flush_i && !reset_i;
  assign ctrl_DIV_o      = (state_q == ST_START) &&  div_q && !flush_i && !reset_i;
  assign wb_valid_o      = (state_q == ST_DONE) && !flush_i && !reset_i;
  assign wb_exception_o  = wb_valid_o && wb_exc_q;
  assign stall_o         = issue_valid_i && (state_q != ST_DONE);
  assign data_operandA_o = op_a_q;
  assign data_operandB_o = op_b_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_result_o     = wb_result_q;

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

- Initiator for the `multdiv` unit:
  - accepts a multiply/divide instruction from the execute stage and drives the one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse;
  - holds operands stable and stalls the pipeline until `data_resultRDY`;
  - returns the result, or the rstatus exception write, to writeback.
- Sits between the X stage and `multdiv`, and owns the pipeline stall for multi-cycle operations.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before the op is forced to complete as an exception.
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `issue_valid`  in  1  mult/div instruction present in X
- `issue_is_div`  in  1  0 = multiply, 1 = divide
- `issue_A`, `issue_B`  in  32 each  operands
- `issue_rd`  in  5  destination register
- `flush`  in  1  kill any in-flight op
- `ctrl_MULT`, `ctrl_DIV`  out  1 each  one-cycle start pulses to `multdiv`
- `data_operandA`, `data_operandB`  out  32 each  registered operands
- `data_result`  in  32  from `multdiv`
- `data_exception`, `data_resultRDY`  in  1 each  from `multdiv`
- `stall`  out  1  hold X and earlier stages
- `wb_valid`  out  1  one-cycle writeback strobe
- `wb_rd`  out  5  writeback register
- `wb_result`  out  32  writeback data
- `wb_exception`  out  1  op completed as exception

## Operation
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE→START on `issue_valid & !flush`; this is the accept. At accept, latch `issue_A`, `issue_B`, `issue_rd` and `issue_is_div`.
  - START→WAIT unconditionally. In START, pulse exactly one of `ctrl_MULT` or `ctrl_DIV`, per the latched op.
  - WAIT→DONE on `data_resultRDY`. Capture `data_result` and `data_exception` in that cycle.
  - WAIT→DONE on timeout, when the cycle counter reaches `TIMEOUT`. Treated as an exception.
  - DONE→IDLE unconditionally. `wb_valid` is 1 only in DONE.
- `data_resultRDY` is ignored in IDLE, START and DONE. Stale RDY from an abandoned op is harmless.
- `stall = issue_valid & (state != DONE)`.
  - In DONE, stall drops, so the instruction leaves X together with its writeback.
  - The next instruction arrives while in IDLE.
- Writeback values:
  - Normal: `wb_rd` = latched rd; `wb_result` = captured result.
  - Exception or timeout: `wb_rd` = 30; `wb_result` = 4 for mult, 5 for div; `wb_exception` = 1.
- `flush` in any state sends the FSM to IDLE next cycle.
  - No `wb_valid` is produced and no ctrl pulse is produced for the killed op.
  - A flush in IDLE blocks accept that cycle.
  - `flush` beats RDY and timeout arriving in the same cycle.
- Operands and the latched op are held constant from START through DONE.

## Timing
- Reset values:
  - FSM = IDLE; counter = 0.
  - `ctrl_MULT`, `ctrl_DIV`, `wb_valid`, `wb_exception` = 0.
  - `stall` follows `issue_valid` combinationally.
  - `data_operandA/B`, `wb_result` = 0; `wb_rd` = 0.
- Latency, with accept at cycle N:
  - ctrl pulse at N+1;
  - WAIT from N+2;
  - RDY sampled at cycle M gives `wb_valid` at M+1.
  - Minimum total is 4 cycles.
- Counter:
  - cleared on entry to WAIT; increments each WAIT cycle;
  - width is `$clog2(TIMEOUT+1)`, saturating;
  - timeout fires when counter == `TIMEOUT` and RDY is low. RDY on that same cycle wins as a normal completion.
- Reset mid-op:
  - returns to IDLE next edge;
  - the pending ctrl pulse and the writeback are suppressed.
- Back-to-back: the earliest possible next accept is the cycle after DONE, in IDLE.

## Structure
- Package `multdiv_pkg`:
  - state enum;
  - `RSTATUS_REG` = 30;
  - `RSTATUS_MULT` = 4;
  - `RSTATUS_DIV` = 5.
- Sub-module `multdiv_watchdog` holds the clearable saturating counter with a `TIMEOUT` compare output.
- The FSM, operand/result registers and writeback mux stay in the top.

## Test plan
- Mult 7 × −3, rd=5: a single `ctrl_MULT` pulse at N+1; `wb_valid` with `wb_result`=0xFFFFFFEB and `wb_rd`=5; stall low only in DONE.
- Div 0x80000000 / −1 and div 10 / 0, with `multdiv` raising `data_exception`: `wb_rd`=30, `wb_result`=5, `wb_exception`=1.
- Back-to-back: mult then div, each held in X under stall. Each op gets exactly one ctrl pulse and one `wb_valid`, in order, with no re-accept during DONE.
- `flush` 10 cycles into WAIT, then RDY 20 cycles later: no `wb_valid`, and the FSM is in IDLE; a new op is accepted normally afterwards.
- Stubbed `multdiv` never asserts RDY, with `TIMEOUT`=8: `wb_valid` comes exactly 8 WAIT cycles after START, with `wb_rd`=30 and `wb_result`=4 for mult.
- `reset` asserted in START and again in WAIT: no ctrl pulse and no writeback, and all outputs hold their reset values next cycle.
